// File: rtl/spi_reg_slave_if.sv
// Register-bank side of spi_reg_slave: one-cycle wr/rd strobes, held address and write data,
// read data returned by the bank exactly one cycle after reg_rd.
interface spi_reg_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 20
);
  logic                  reg_wr;
  logic                  reg_rd;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport master (output reg_wr, reg_rd, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_wr, reg_rd, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 target turning rw/addr/data frames into register strobes; trailing parity bit under SPI_SLAVE_PARITY_EN.
// Latency: pins act SYNC_STAGES+1 cycles after changing; strobes follow the completing SCLK edge by one cycle.
// Backpressure: none; the bank takes a strobe any cycle and returns read data one cycle after reg_rd.
module spi_reg_slave #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_clk_sys,
  input  logic            i_rst,
  input  logic            i_spi_sclk,
  input  logic            i_spi_cs_n,
  input  logic            i_spi_mosi,
  output logic            o_spi_miso,
  output logic            o_spi_miso_oe,
  output logic            o_frame_done,
  output logic            o_frame_err,
  output logic            o_busy,
  spi_reg_slave_if.master reg_bus
);

  localparam int L = 1 + ADDR_WIDTH + DATA_WIDTH;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int FL  = L + 1;
  localparam int DSW = DATA_WIDTH;
`else
  localparam int FL  = L;
  localparam int DSW = DATA_WIDTH - 1;
`endif
  localparam int CW = $clog2(FL + 1) + 2;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s, sync_ok;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  // Ignore edges until the pipeline holds real pin samples, not reset values.
  assign sync_ok  = fill[SYNC_STAGES];
  assign sck_rise = sync_ok & sclk_s & ~sclk_d;
  assign sck_fall = sync_ok & ~sclk_s & sclk_d;
  assign cs_rise  = sync_ok & cs_s & ~cs_d;
  assign cs_fall  = sync_ok & ~cs_s & cs_d;

  state_t                state_q, state_d;
  logic                  armed;
  logic [CW-1:0]         cnt;
  logic                  active, start, close, sr_edge, sf_edge, last_addr, last_data;
  logic                  rw_q, fell_q, rd_q, ld_q, wr_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_sh, addr_nxt, reg_addr_q;
  logic [DSW-1:0]        data_sh;
  logic [DATA_WIDTH-1:0] data_nxt, reg_wdata_q, tx_sh;
  logic                  frame_ok;
`ifdef SPI_SLAVE_PARITY_EN
  logic                  par_q, par_bad, rpar_q;
  assign frame_ok = (cnt == CW'(FL)) && !par_bad;
`else
  assign frame_ok = (cnt == CW'(FL));
`endif

  assign active    = (state_q != S_IDLE);
  assign start     = (state_q == S_IDLE) && armed && cs_fall;
  assign close     = active && cs_rise;
  // cs_n rise outranks an SCLK edge detected in the same cycle.
  assign sr_edge   = active && sck_rise && !cs_rise;
  assign sf_edge   = active && sck_fall && !cs_rise;
  assign last_addr = (cnt == CW'(ADDR_WIDTH));
  assign last_data = (cnt == CW'(L - 1));
  assign addr_nxt  = {addr_sh[ADDR_WIDTH-2:0], mosi_s};
  assign data_nxt  = {data_sh[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CMD;
      S_CMD:  if (sr_edge) state_d = S_ADDR;
      S_ADDR: if (sr_edge && last_addr) state_d = S_DATA;
      S_DATA: if (sr_edge && last_data) state_d = S_DONE;
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    if (close) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      armed       <= 1'b0;
      cnt         <= '0;
      rw_q        <= 1'b0;
      fell_q      <= 1'b0;
      rd_q        <= 1'b0;
      ld_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_sh     <= '0;
      data_sh     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      tx_sh       <= '0;
`ifdef SPI_SLAVE_PARITY_EN
      par_q       <= 1'b0;
      par_bad     <= 1'b0;
      rpar_q      <= 1'b0;
`endif
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= rd_q;

      if (start)                armed <= 1'b0;
      else if (sync_ok && cs_s) armed <= 1'b1;

      if (start) begin
        cnt    <= '0;
        rw_q   <= 1'b0;
        fell_q <= 1'b0;
        tx_sh  <= '0;
`ifdef SPI_SLAVE_PARITY_EN
        par_q   <= 1'b0;
        par_bad <= 1'b0;
`endif
      end

      if (sr_edge) begin
        if (cnt != '1) cnt <= cnt + CW'(1);
`ifdef SPI_SLAVE_PARITY_EN
        if (cnt < CW'(L)) par_q <= par_q ^ mosi_s;
`endif
        case (state_q)
          S_CMD: rw_q <= mosi_s;
          S_ADDR: begin
            addr_sh <= addr_nxt;
            if (last_addr && !rw_q) begin
              rd_q       <= 1'b1;
              reg_addr_q <= addr_nxt;
            end
          end
          S_DATA: begin
            data_sh <= DSW'(data_nxt);
`ifndef SPI_SLAVE_PARITY_EN
            if (last_data && rw_q) begin
              wr_q        <= 1'b1;
              reg_addr_q  <= addr_sh;
              reg_wdata_q <= data_nxt;
            end
`endif
          end
          S_DONE: begin
`ifdef SPI_SLAVE_PARITY_EN
            if (cnt == CW'(L)) begin
              par_bad <= (par_q != mosi_s);
              if (rw_q && (par_q == mosi_s)) begin
                wr_q        <= 1'b1;
                reg_addr_q  <= addr_sh;
                reg_wdata_q <= data_sh;
              end
            end
`endif
          end
          default: ;
        endcase
      end

      if (sf_edge && state_q == S_DATA) fell_q <= 1'b1;

      // The first DATA falling edge leaves the MSB in place for the first data bit.
      if (ld_q) begin
        tx_sh <= reg_bus.reg_rdata;
`ifdef SPI_SLAVE_PARITY_EN
        rpar_q <= ^reg_bus.reg_rdata;
`endif
      end else if (sf_edge && state_q == S_DATA && !rw_q && fell_q) begin
        tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      end

      if (close) begin
        done_q <= frame_ok;
        err_q  <= !frame_ok;
      end
    end
  end

  always_comb begin
    o_spi_miso = 1'b0;
    if (!rw_q) begin
      if (state_q == S_DATA) o_spi_miso = tx_sh[DATA_WIDTH-1];
`ifdef SPI_SLAVE_PARITY_EN
      else if (state_q == S_DONE && cnt == CW'(L)) o_spi_miso = rpar_q;
`endif
    end
  end

  assign o_spi_miso_oe     = active;
  assign o_busy            = active;
  assign o_frame_done      = done_q;
  assign o_frame_err       = err_q;
  assign reg_bus.reg_wr    = wr_q;
  assign reg_bus.reg_rd    = rd_q;
  assign reg_bus.reg_addr  = reg_addr_q;
  assign reg_bus.reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: SPI master bit-bang, register-bank model, strobe monitor.
module tb_spi_reg_slave;
  localparam int AW = 6;
  localparam int DW = 20;
  localparam int L  = 27;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int FL = L + 1;
`else
  localparam int FL = L;
`endif
  localparam int HP = 8;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, frame_done, frame_err, busy;

  spi_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  spi_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .i_clk_sys     (clk),
    .i_rst         (rst),
    .i_spi_sclk    (sclk),
    .i_spi_cs_n    (cs_n),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso),
    .o_spi_miso_oe (miso_oe),
    .o_frame_done  (frame_done),
    .o_frame_err   (frame_err),
    .o_busy        (busy),
    .reg_bus       (bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rd_val = '0;
  always @(posedge clk or posedge rst) begin
    if (rst)             bus.reg_rdata <= '0;
    else if (bus.reg_rd) bus.reg_rdata <= rd_val;
  end

  int wr_cnt, rd_cnt, done_cnt, err_cnt, rise_no, wr_at;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  always @(negedge clk) begin
    if (bus.reg_wr) begin
      wr_cnt++;
      waddr = bus.reg_addr;
      wdata = bus.reg_wdata;
      wr_at = rise_no;
    end
    if (bus.reg_rd) begin
      rd_cnt++;
      raddr = bus.reg_addr;
    end
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  int ncmp = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0; rise_no = 0; wr_at = -1;
    waddr = '0; raddr = '0; wdata = '0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(HP);
  endtask

  task automatic cs_high();
    tick(HP);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(3 * HP);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled as SCLK rises.
  task automatic send(input int n, input logic [31:0] fr, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = fr[i];
      tick(HP);
      sclk = 1'b1;
      rise_no++;
      rx = {rx[30:0], miso};
      tick(HP);
      sclk = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [L-1:0] b;
    b = {rw, a, d};
`ifdef SPI_SLAVE_PARITY_EN
    return {4'b0, b, ^b};
`else
    return {5'b0, b};
`endif
  endfunction

  logic [31:0] rx;

  initial begin
    clr();
    tick(4);
    rst = 1'b0;
    tick(HP);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_oe", {31'b0, miso_oe}, 32'd0);
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_done_err", {30'b0, frame_done, frame_err}, 32'd0);
    chk("rst_strobes", {30'b0, bus.reg_wr, bus.reg_rd}, 32'd0);
    chk("rst_addr", {26'b0, bus.reg_addr}, 32'd0);
    chk("rst_wdata", {12'b0, bus.reg_wdata}, 32'd0);

    // Full write frame
    clr(); cs_low(); send(FL, mk(1'b1, 6'h2A, 20'hABCDE), rx); cs_high();
    chk("wr_count", wr_cnt, 1);
    chk("wr_addr", {26'b0, waddr}, 32'h2A);
    chk("wr_data", {12'b0, wdata}, 32'hABCDE);
    chk("wr_at_bit", wr_at, FL);
    chk("wr_done", done_cnt, 1);
    chk("wr_err", err_cnt, 0);
    chk("wr_no_rd", rd_cnt, 0);

    // Read frame; MOSI data bits are don't-care
    rd_val = 20'h5A5A5;
    clr(); cs_low(); send(FL, mk(1'b0, 6'h05, 20'h0F0F0), rx);
    chk("rd_busy", {31'b0, busy}, 32'd1);
    chk("rd_oe", {31'b0, miso_oe}, 32'd1);
    cs_high();
    chk("rd_count", rd_cnt, 1);
    chk("rd_addr", {26'b0, raddr}, 32'h05);
    chk("rd_miso_hdr", rx >> (FL - 1 - AW), 32'd0);
    chk("rd_miso_data", {12'b0, DW'(rx >> (FL - L))}, 32'h5A5A5);
`ifdef SPI_SLAVE_PARITY_EN
    chk("rd_miso_par", {31'b0, rx[0]}, 32'd0);
`endif
    chk("rd_no_wr", wr_cnt, 0);
    chk("rd_done", done_cnt, 1);

    // Write aborted after 10 bits, then a normal frame
    clr(); cs_low(); send(10, mk(1'b1, 6'h15, 20'h12345) >> (FL - 10), rx); cs_high();
    chk("abort_no_wr", wr_cnt, 0);
    chk("abort_err", err_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    clr(); cs_low(); send(FL, mk(1'b1, 6'h15, 20'h12345), rx); cs_high();
    chk("after_abort_wr", wr_cnt, 1);
    chk("after_abort_data", {12'b0, wdata}, 32'h12345);
    chk("after_abort_done", done_cnt, 1);

    // Reset mid-frame, released with cs_n still low
    clr(); cs_low(); send(10, 32'h3FF, rx);
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    send(17, 32'h1FFFF, rx);
    cs_high();
    chk("midrst_strobes", wr_cnt + rd_cnt, 0);
    chk("midrst_close", done_cnt + err_cnt, 0);
    clr(); cs_low(); send(FL, mk(1'b1, 6'h3F, 20'hFFFFF), rx); cs_high();
    chk("rearm_wr", wr_cnt, 1);
    chk("rearm_addr", {26'b0, waddr}, 32'h3F);
    chk("rearm_data", {12'b0, wdata}, 32'hFFFFF);
    chk("rearm_done", done_cnt, 1);

    // Two extra clocks past a full write frame
    clr(); cs_low(); send(FL + 2, (mk(1'b1, 6'h0C, 20'h54321) << 2) | 32'h3, rx); cs_high();
    chk("long_wr", wr_cnt, 1);
    chk("long_wr_at", wr_at, FL);
    chk("long_data", {12'b0, wdata}, 32'h54321);
    chk("long_err", err_cnt, 1);
    chk("long_no_done", done_cnt, 0);
    chk("long_miso_tail", {30'b0, rx[1:0]}, 32'd0);

`ifdef SPI_SLAVE_PARITY_EN
    // addr 0x01 / data 0x00001 with rw=1: correct even parity bit is 1
    clr(); cs_low(); send(FL, 32'h8200002, rx); cs_high();
    chk("par_bad_no_wr", wr_cnt, 0);
    chk("par_bad_err", err_cnt, 1);
    chk("par_bad_no_done", done_cnt, 0);
    clr(); cs_low(); send(FL, 32'h8200003, rx); cs_high();
    chk("par_ok_wr", wr_cnt, 1);
    chk("par_ok_data", {12'b0, wdata}, 32'h00001);
    chk("par_ok_done", done_cnt, 1);
    chk("par_ok_err", err_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
